// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and access sequencer for a single-ported data memory
module dmem_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_read,
    input  logic         req0_write,
    input  logic [N-1:0] req0_address,
    input  logic [N-1:0] req0_writedata,
    output logic [N-1:0] req0_readdata,
    output logic         req0_busywait,
    input  logic         req1_read,
    input  logic         req1_write,
    input  logic [N-1:0] req1_address,
    input  logic [N-1:0] req1_writedata,
    output logic [N-1:0] req1_readdata,
    output logic         req1_busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_writedata,
    input  logic [N-1:0] mem_readdata,
    input  logic         mem_busywait,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t       state_q;
    logic         grant_q;
    logic         last_q;
    logic         mem_read_q;
    logic         mem_write_q;
    logic [N-1:0] mem_address_q;
    logic [N-1:0] mem_writedata_q;
    logic [N-1:0] rd0_q;
    logic [N-1:0] rd1_q;
    logic         timeout_err_q;
    logic [15:0]  cnt_q;

    logic req0_valid;
    logic req1_valid;
    logic req0_illegal;
    logic req1_illegal;
    logic sel_d;

    // A port asserting both strobes is not a request at all; it only flags an error.
    always_comb begin
        req0_valid   = req0_read ^ req0_write;
        req1_valid   = req1_read ^ req1_write;
        req0_illegal = req0_read & req0_write;
        req1_illegal = req1_read & req1_write;
        sel_d        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    end

    assign req0_busywait = (req0_read | req0_write) & ~(state_q == DONE && !grant_q);
    assign req1_busywait = (req1_read | req1_write) & ~(state_q == DONE && grant_q);

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign req0_readdata = rd0_q;
    assign req1_readdata = rd1_q;
    assign timeout_err   = timeout_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            grant_q         <= 1'b0;
            last_q          <= 1'b1;  // port 1 "went last", so port 0 wins the first tie
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            rd0_q           <= '0;
            rd1_q           <= '0;
            timeout_err_q   <= 1'b0;
            cnt_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_illegal || req1_illegal)
                        timeout_err_q <= 1'b1;
                    if (req0_valid || req1_valid) begin
                        grant_q         <= sel_d;
                        last_q          <= sel_d;
                        mem_read_q      <= sel_d ? req1_read      : req0_read;
                        mem_write_q     <= sel_d ? req1_write     : req0_write;
                        mem_address_q   <= sel_d ? req1_address   : req0_address;
                        mem_writedata_q <= sel_d ? req1_writedata : req0_writedata;
                        cnt_q           <= '0;
                        state_q         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!mem_busywait) begin
                        if (mem_read_q) begin
                            if (grant_q) rd1_q <= mem_readdata;
                            else         rd0_q <= mem_readdata;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                    end else if (cnt_q == TMO) begin
                        // Aborted reads return zero so stale data is never mistaken for a result.
                        if (mem_read_q) begin
                            if (grant_q) rd1_q <= '0;
                            else         rd0_q <= '0;
                        end
                        mem_read_q    <= 1'b0;
                        mem_write_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_read, req0_write, req1_read, req1_write;
    logic [7:0] req0_address, req0_writedata, req1_address, req1_writedata;
    logic [7:0] req0_readdata, req1_readdata;
    logic       req0_busywait, req1_busywait;
    logic       mem_read, mem_write, mem_busywait, timeout_err;
    logic [7:0] mem_address, mem_writedata, mem_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: busywait high for L cycles of each access, stuck forces it high forever.
    logic [7:0] mem_arr [256];
    int         lat_q = 0;
    int         L     = 0;
    logic       stuck = 1'b0;

    assign mem_busywait = stuck | ((mem_read | mem_write) && (lat_q < L));
    assign mem_readdata = mem_arr[mem_address];

    always @(posedge clk) begin
        if ((mem_read || mem_write) && !stuck) begin
            if (lat_q < L) lat_q <= lat_q + 1;
            else begin
                if (mem_write) mem_arr[mem_address] = mem_writedata;
                lat_q <= 0;
            end
        end else begin
            lat_q <= 0;
        end
    end

    always #5 clk = ~clk;

    dmem_arbiter #(.N(8), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req0_read(req0_read), .req0_write(req0_write), .req0_address(req0_address),
        .req0_writedata(req0_writedata), .req0_readdata(req0_readdata), .req0_busywait(req0_busywait),
        .req1_read(req1_read), .req1_write(req1_write), .req1_address(req1_address),
        .req1_writedata(req1_writedata), .req1_readdata(req1_readdata), .req1_busywait(req1_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
        n_checks++; if ({mem_address, mem_writedata} !== 16'h0) begin n_fail++; $display("FAIL reset_mem_bus got=%h exp=0000", {mem_address, mem_writedata}); end
        n_checks++; if ({req0_readdata, req1_readdata} !== 16'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0000", {req0_readdata, req1_readdata}); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        n_checks++; if ({req0_busywait, req1_busywait} !== 2'b00) begin n_fail++; $display("FAIL reset_busywait got=%b exp=00", {req0_busywait, req1_busywait}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        mem_arr[8'h12] = 8'h5A;
        L = 4;
        req0_read = 1'b1; req0_address = 8'h12;
        tick();
        for (int c = 1; c <= 5; c++) begin
            n_checks++; if ({mem_read, mem_address, req0_busywait} !== {1'b1, 8'h12, 1'b1}) begin n_fail++; $display("FAIL read_access c%0d got rd=%b a=%h bw=%b exp rd=1 a=12 bw=1", c, mem_read, mem_address, req0_busywait); end
            tick();
        end
        n_checks++; if ({mem_read, req0_busywait} !== 2'b00) begin n_fail++; $display("FAIL read_done_ctrl got=%b exp=00", {mem_read, req0_busywait}); end
        n_checks++; if (req0_readdata !== 8'h5A) begin n_fail++; $display("FAIL read_data got=%h exp=5a", req0_readdata); end
        req0_read = 1'b0;
        tick();
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL read_idle got=%b exp=0", mem_read); end
    endtask

    task automatic test_single_write();
        L = 2;
        req1_write = 1'b1; req1_address = 8'h80; req1_writedata = 8'hC3;
        tick();
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if ({mem_write, mem_address, mem_writedata, req1_busywait} !== {1'b1, 8'h80, 8'hC3, 1'b1}) begin n_fail++; $display("FAIL write_access c%0d got w=%b a=%h d=%h bw=%b exp w=1 a=80 d=c3 bw=1", c, mem_write, mem_address, mem_writedata, req1_busywait); end
            tick();
        end
        n_checks++; if ({mem_write, req1_busywait} !== 2'b00) begin n_fail++; $display("FAIL write_done_ctrl got=%b exp=00", {mem_write, req1_busywait}); end
        n_checks++; if (req1_readdata !== 8'h00) begin n_fail++; $display("FAIL write_readdata_kept got=%h exp=00", req1_readdata); end
        req1_write = 1'b0;
        tick();
        L = 0;
        req0_read = 1'b1; req0_address = 8'h80;
        tick();
        n_checks++; if ({mem_read, mem_address} !== {1'b1, 8'h80}) begin n_fail++; $display("FAIL zero_lat_access got rd=%b a=%h exp rd=1 a=80", mem_read, mem_address); end
        tick();
        n_checks++; if ({req0_readdata, req0_busywait, mem_read} !== {8'hC3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL readback got d=%h bw=%b rd=%b exp d=c3 bw=0 rd=0", req0_readdata, req0_busywait, mem_read); end
        req0_read = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [7:0] exp_a;
        logic       bw_p, bw_o;
        logic [7:0] rd_p;
        int         ph, p;
        mem_arr[8'h10] = 8'h11; mem_arr[8'h20] = 8'h22;
        L = 1;
        req0_read = 1'b1; req0_address = 8'h10;
        req1_read = 1'b1; req1_address = 8'h20;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int c = 1; c <= 15; c++) begin
            ph    = (c - 1) % 4;
            p     = ((c - 1) / 4) % 2;
            exp_a = (p == 1) ? 8'h20 : 8'h10;
            bw_p  = (p == 1) ? req1_busywait : req0_busywait;
            bw_o  = (p == 1) ? req0_busywait : req1_busywait;
            rd_p  = (p == 1) ? req1_readdata : req0_readdata;
            if (ph < 2) begin
                n_checks++; if ({mem_read, mem_address} !== {1'b1, exp_a}) begin n_fail++; $display("FAIL contend_access c%0d got rd=%b a=%h exp rd=1 a=%h", c, mem_read, mem_address, exp_a); end
            end else if (ph == 2) begin
                n_checks++; if ({bw_p, bw_o} !== 2'b01) begin n_fail++; $display("FAIL contend_bw c%0d got granted/other=%b exp=01", c, {bw_p, bw_o}); end
                n_checks++; if (rd_p !== ((p == 1) ? 8'h22 : 8'h11)) begin n_fail++; $display("FAIL contend_data c%0d port%0d got=%h", c, p, rd_p); end
            end else begin
                n_checks++; if ({mem_read, req0_busywait, req1_busywait} !== 3'b011) begin n_fail++; $display("FAIL contend_idle c%0d got=%b exp=011", c, {mem_read, req0_busywait, req1_busywait}); end
            end
            if (c == 15) begin req0_read = 1'b0; req1_read = 1'b0; end
            tick();
        end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL contend_end got=%b exp=0", mem_read); end
    endtask

    task automatic test_timeout();
        stuck = 1'b1;
        req0_read = 1'b1; req0_address = 8'h12;
        tick();
        for (int c = 1; c <= 9; c++) begin
            n_checks++; if ({mem_read, timeout_err, req0_busywait} !== 3'b101) begin n_fail++; $display("FAIL timeout_access c%0d got rd/err/bw=%b exp=101", c, {mem_read, timeout_err, req0_busywait}); end
            tick();
        end
        n_checks++; if ({mem_read, timeout_err, req0_busywait} !== 3'b010) begin n_fail++; $display("FAIL timeout_abort got rd/err/bw=%b exp=010", {mem_read, timeout_err, req0_busywait}); end
        n_checks++; if (req0_readdata !== 8'h00) begin n_fail++; $display("FAIL timeout_readdata got=%h exp=00", req0_readdata); end
        req0_read = 1'b0; stuck = 1'b0;
        tick(); tick(); tick();
        n_checks++; if ({timeout_err, mem_read} !== 2'b10) begin n_fail++; $display("FAIL timeout_sticky got err/rd=%b exp=10", {timeout_err, mem_read}); end
    endtask

    task automatic test_reset_mid_access();
        L = 10;
        req1_read = 1'b1; req1_address = 8'h12;
        tick();
        n_checks++; if ({mem_read, mem_address} !== {1'b1, 8'h12}) begin n_fail++; $display("FAIL rstmid_start got rd=%b a=%h exp rd=1 a=12", mem_read, mem_address); end
        tick(); tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({mem_read, timeout_err, req1_readdata, mem_address} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin n_fail++; $display("FAIL rstmid got rd=%b err=%b d=%h a=%h exp rd=0 err=0 d=00 a=00", mem_read, timeout_err, req1_readdata, mem_address); end
        n_checks++; if (req1_busywait !== 1'b1) begin n_fail++; $display("FAIL rstmid_bw got=%b exp=1", req1_busywait); end
        req1_read = 1'b0; reset = 1'b0;
        tick(); tick();
        n_checks++; if ({mem_read, mem_write, req1_busywait} !== 3'b000) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=000", {mem_read, mem_write, req1_busywait}); end
    endtask

    task automatic test_illegal();
        L = 1;
        req0_read = 1'b1; req0_write = 1'b1; req0_address = 8'h33;
        req1_write = 1'b1; req1_address = 8'h44; req1_writedata = 8'h99;
        tick();
        n_checks++; if ({mem_write, mem_read, mem_address, mem_writedata} !== {1'b1, 1'b0, 8'h44, 8'h99}) begin n_fail++; $display("FAIL illegal_grant got w=%b r=%b a=%h d=%h exp w=1 r=0 a=44 d=99", mem_write, mem_read, mem_address, mem_writedata); end
        n_checks++; if ({timeout_err, req0_busywait} !== 2'b11) begin n_fail++; $display("FAIL illegal_err got err/bw0=%b exp=11", {timeout_err, req0_busywait}); end
        tick(); tick();
        n_checks++; if ({req1_busywait, req0_busywait, mem_write} !== 3'b010) begin n_fail++; $display("FAIL illegal_done got bw1/bw0/w=%b exp=010", {req1_busywait, req0_busywait, mem_write}); end
        req1_write = 1'b0;
        tick(); tick(); tick();
        n_checks++; if ({mem_read, mem_write, req0_busywait} !== 3'b001) begin n_fail++; $display("FAIL illegal_never_granted got=%b exp=001", {mem_read, mem_write, req0_busywait}); end
        n_checks++; if (mem_arr[8'h44] !== 8'h99) begin n_fail++; $display("FAIL illegal_mem_write got=%h exp=99", mem_arr[8'h44]); end
        n_checks++; if (req0_readdata !== 8'h00) begin n_fail++; $display("FAIL illegal_rd0 got=%h exp=00", req0_readdata); end
        req0_read = 1'b0; req0_write = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        reset = 1'b1;
        req0_read = 1'b0; req0_write = 1'b0; req0_address = 8'h00; req0_writedata = 8'h00;
        req1_read = 1'b0; req1_write = 1'b0; req1_address = 8'h00; req1_writedata = 8'h00;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_timeout();
        test_reset_mid_access();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
